// File: rtl/pool_max_seq_if.sv
// Handshake and data bundle between the 2x2 window mux / consumer and pool_max_seq.
// master drives the request side and the window pixels; slave is the pooling engine.
interface pool_max_seq_if;
   logic              start;
   logic              busy;
   logic [3:0]        cnt;
   logic signed [7:0] conv0;
   logic signed [7:0] conv1;
   logic signed [7:0] conv2;
   logic signed [7:0] conv3;
   logic              out_valid;
   logic              out_ready;
   logic [71:0]       pool_lin;

   modport master (
      output start, conv0, conv1, conv2, conv3, out_ready,
      input  busy, cnt, out_valid, pool_lin
   );

   modport slave (
      input  start, conv0, conv1, conv2, conv3, out_ready,
      output busy, cnt, out_valid, pool_lin
   );
endinterface

// File: rtl/pool_max_seq.sv
// Sequential 2x2 max-pool of a 6x6 map into a 3x3 map, one window per cycle.
// Define POOL_RELU_EN to clamp negative maxima to zero before storing.
module pool_max_seq (
   input logic          clk,
   input logic          rst_n,
   pool_max_seq_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [71:0]       pool_q, pool_d;
   logic signed [7:0] max01, max23, win_max, elem;

   // Signed tree max; ties resolve to either operand, which is the same value.
   always_comb begin
      max01   = ($signed(bus.conv0) >= $signed(bus.conv1)) ? bus.conv0 : bus.conv1;
      max23   = ($signed(bus.conv2) >= $signed(bus.conv3)) ? bus.conv2 : bus.conv3;
      win_max = (max01 >= max23) ? max01 : max23;
`ifdef POOL_RELU_EN
      elem    = win_max[7] ? 8'sh00 : win_max;
`else
      elem    = win_max;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pool_d  = pool_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               cnt_d   = 4'd0;
            end
         end
         StRun: begin
            for (int k = 0; k < 9; k++) begin
               if (cnt_q == 4'(k)) pool_d[k*8 +: 8] = elem;
            end
            if (cnt_q == 4'd8) begin
               state_d = StDone;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         pool_q  <= 72'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pool_q  <= pool_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.cnt       = cnt_q;
   assign bus.pool_lin  = pool_q;
endmodule

// File: tb/tb_pool_max_seq.sv
// Self-checking bench for pool_max_seq: window mux model, scoreboard of pooled maps.
module tb_pool_max_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pool_max_seq_if bus ();

   pool_max_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0]  pix [9][4];
   logic [71:0] exp_q [$];
   int tests = 0;
   int fails = 0;

`ifdef POOL_RELU_EN
   localparam logic [7:0] ExpNeg = 8'h00;
   localparam logic [7:0] Exp85  = 8'h00;
`else
   localparam logic [7:0] ExpNeg = 8'hFF;
   localparam logic [7:0] Exp85  = 8'h85;
`endif

   // Window mux: returns the four pixels of window cnt.
   always_comb begin
      bus.conv0 = '0;
      bus.conv1 = '0;
      bus.conv2 = '0;
      bus.conv3 = '0;
      if (bus.cnt < 4'd9) begin
         bus.conv0 = pix[bus.cnt][0];
         bus.conv1 = pix[bus.cnt][1];
         bus.conv2 = pix[bus.cnt][2];
         bus.conv3 = pix[bus.cnt][3];
      end
   end

   function automatic logic [71:0] model_pool();
      logic [71:0]       res;
      logic signed [7:0] m;
      res = '0;
      for (int k = 0; k < 9; k++) begin
         m = pix[k][0];
         for (int j = 1; j < 4; j++) if ($signed(pix[k][j]) > m) m = pix[k][j];
`ifdef POOL_RELU_EN
         if (m < 0) m = 8'sh00;
`endif
         res[k*8 +: 8] = m;
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic random_map();
      for (int k = 0; k < 9; k++)
         for (int j = 0; j < 4; j++) pix[k][j] = 8'($urandom);
   endtask

   // One complete run with a given number of stall cycles in DONE.
   task automatic run_map(input int stall, output logic [71:0] got);
      logic [71:0] exp;
      exp_q.push_back(model_pool());
      bus.out_ready = (stall == 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tests++;
      if (bus.busy !== 1'b1 || bus.cnt !== 4'd0) begin
         fails++;
         $display("FAIL run_start: busy=%b cnt=%0d, required busy=1 cnt=0", bus.busy, bus.cnt);
      end
      for (int n = 1; n <= 8; n++) begin
         tick();
         tests++;
         if (bus.cnt !== 4'(n) || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL run_cnt: cnt=%0d out_valid=%b, required cnt=%0d out_valid=0",
                     bus.cnt, bus.out_valid, n);
         end
      end
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.cnt !== 4'd0) begin
         fails++;
         $display("FAIL latency: out_valid=%b cnt=%0d, required out_valid=1 cnt=0",
                  bus.out_valid, bus.cnt);
      end
      got = bus.pool_lin;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL scoreboard: queue empty, required one entry");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            fails++;
            $display("FAIL pool_lin: got %h required %h", got, exp);
         end
      end
      for (int s = 0; s < stall; s++) begin
         bus.start = s[0];
         tick();
         tests++;
         if (bus.out_valid !== 1'b1 || bus.pool_lin !== got || bus.cnt !== 4'd0) begin
            fails++;
            $display("FAIL stall_hold: out_valid=%b cnt=%0d pool_lin=%h, required 1 0 %h",
                     bus.out_valid, bus.cnt, bus.pool_lin, got);
         end
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL to_idle: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
      end
      tick();
      tests++;
      if (bus.pool_lin !== got || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: pool_lin=%h busy=%b, required %h 0", bus.pool_lin, bus.busy, got);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.cnt !== 4'd0) begin
         fails++;
         $display("FAIL reset_ctrl: busy=%b out_valid=%b cnt=%0d, required 0 0 0",
                  bus.busy, bus.out_valid, bus.cnt);
      end
      tests++;
      if (bus.pool_lin !== 72'd0) begin
         fails++;
         $display("FAIL reset_pool: got %h required 0", bus.pool_lin);
      end
      bus.start = 1'b0;
      rst_n = 1'b1;
      tick();
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_start: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_basic();
      logic [71:0] got;
      for (int k = 0; k < 9; k++)
         for (int j = 0; j < 4; j++) pix[k][j] = 8'(k + j);
      run_map(0, got);
      for (int k = 0; k < 9; k++) begin
         tests++;
         if (got[k*8 +: 8] !== 8'(k + 3)) begin
            fails++;
            $display("FAIL basic_elem%0d: got %h required %h", k, got[k*8 +: 8], 8'(k + 3));
         end
      end
   endtask

   task automatic test_signed();
      logic [71:0] got;
      random_map();
      pix[4][0] = 8'hF0; pix[4][1] = 8'h80; pix[4][2] = 8'hFF; pix[4][3] = 8'hC0;
      pix[0][0] = 8'h7F; pix[0][1] = 8'h80; pix[0][2] = 8'h00; pix[0][3] = 8'h01;
      for (int j = 0; j < 4; j++) pix[1][j] = 8'h85;
      run_map(0, got);
      tests++;
      if (got[32 +: 8] !== ExpNeg) begin
         fails++;
         $display("FAIL signed_neg: got %h required %h", got[32 +: 8], ExpNeg);
      end
      tests++;
      if (got[0 +: 8] !== 8'h7F) begin
         fails++;
         $display("FAIL signed_extreme: got %h required 7f", got[0 +: 8]);
      end
      tests++;
      if (got[8 +: 8] !== Exp85) begin
         fails++;
         $display("FAIL signed_equal: got %h required %h", got[8 +: 8], Exp85);
      end
   endtask

   task automatic test_stall();
      logic [71:0] got;
      random_map();
      run_map(5, got);
   endtask

   task automatic test_reset_mid();
      int bad;
      random_map();
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 0; n < 5; n++) tick();
      tests++;
      if (bus.cnt !== 4'd5) begin
         fails++;
         $display("FAIL mid_cnt: got %0d required 5", bus.cnt);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++;
      if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.pool_lin !== 72'd0 ||
          bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: cnt=%0d busy=%b out_valid=%b pool_lin=%h, required 0 0 0 0",
                  bus.cnt, bus.busy, bus.out_valid, bus.pool_lin);
      end
      bad = 0;
      for (int n = 0; n < 15; n++) begin
         tick();
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL mid_no_valid: %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [71:0] exp;
      logic [3:0]  exp_cnt;
      logic        exp_busy, exp_ov;
      int          p;
      random_map();
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      exp_q.push_back(model_pool());
      tick();
      for (int cyc = 1; cyc <= 33; cyc++) begin
         tick();
         p = cyc % 11;
         exp_cnt  = (p >= 1 && p <= 8) ? 4'(p) : 4'd0;
         exp_busy = (p != 10);
         exp_ov   = (p == 9);
         tests++;
         if (bus.cnt !== exp_cnt || bus.busy !== exp_busy || bus.out_valid !== exp_ov) begin
            fails++;
            $display("FAIL b2b_cyc%0d: cnt=%0d busy=%b out_valid=%b, required %0d %b %b",
                     cyc, bus.cnt, bus.busy, bus.out_valid, exp_cnt, exp_busy, exp_ov);
         end
         if (p == 9) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL b2b_scoreboard: queue empty, required one entry");
            end else begin
               exp = exp_q.pop_front();
               if (bus.pool_lin !== exp) begin
                  fails++;
                  $display("FAIL b2b_pool: got %h required %h", bus.pool_lin, exp);
               end
            end
         end
         if (p == 10 && cyc < 30) exp_q.push_back(model_pool());
      end
      bus.start = 1'b0;
      for (int n = 0; n < 11; n++) tick();
      tests++;
      if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL b2b_drain: busy=%b queued=%0d, required 0 0", bus.busy, exp_q.size());
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 9; k++)
         for (int j = 0; j < 4; j++) pix[k][j] = 8'h00;
      test_reset();
      test_basic();
      test_signed();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
